// File: rtl/instruction_encoder_pkg.sv
// Shared field geometry and FSM states for the instruction encoder and its packer.
package instruction_encoder_pkg;

  localparam int unsigned WordW    = 16;
  localparam int unsigned OpcodeW  = 4;
  localparam int unsigned RegW     = 3;
  localparam int unsigned ImmW     = 6;

  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RdLsb     = 9;
  localparam int unsigned Rs1Lsb    = 6;
  localparam int unsigned Rs2Lsb    = 3;
  localparam int unsigned ImmLsb    = 0;

  typedef enum logic [1:0] {
    StIdle,
    StAccept,
    StWrite,
    StDone
  } state_e;

endpackage

// File: rtl/instruction_packer.sv
// Combinational packing of instruction fields into a 16-bit word (register or immediate format).
module instruction_packer
  import instruction_encoder_pkg::*;
(
  input  logic               fmt_imm,
  input  logic [OpcodeW-1:0] opcode,
  input  logic [RegW-1:0]    rd,
  input  logic [RegW-1:0]    rs1,
  input  logic [RegW-1:0]    rs2,
  input  logic [ImmW-1:0]    immediate,
  output logic [WordW-1:0]   word
);

  always_comb begin
    word = '0;
    word[OpcodeLsb +: OpcodeW] = opcode;
    word[RdLsb +: RegW]        = rd;
    word[Rs1Lsb +: RegW]       = rs1;
    // Immediate format reuses the rs2 slot and the low zero bits.
    if (fmt_imm) begin
      word[ImmLsb +: ImmW] = immediate;
    end else begin
      word[Rs2Lsb +: RegW] = rs2;
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Burst instruction encoder: accepts field sets, writes packed words to consecutive memory
// addresses (one word per two cycles) and reports an XOR checksum at completion.
module instruction_encoder
  import instruction_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [LEN_W-1:0]   length,
  input  logic               abort,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               fmt_imm,
  input  logic [OpcodeW-1:0] opcode,
  input  logic [RegW-1:0]    rd,
  input  logic [RegW-1:0]    rs1,
  input  logic [RegW-1:0]    rs2,
  input  logic [ImmW-1:0]    immediate,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WordW-1:0]   mem_wdata,
  output logic               done,
  output logic [WordW-1:0]   checksum
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [LEN_W-1:0]   length_q, length_d;
  logic [LEN_W-1:0]   index_q, index_d;
  logic [LEN_W-1:0]   index_inc;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [WordW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [WordW-1:0]   checksum_q, checksum_d;
  logic [WordW-1:0]   word;

  instruction_packer u_packer (
    .fmt_imm   (fmt_imm),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .immediate (immediate),
    .word      (word)
  );

  assign index_inc = index_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    length_d    = length_q;
    index_d     = index_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    checksum_d  = checksum_q;
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          index_d    = '0;
          checksum_d = '0;
          if (length != '0) begin
            base_d   = base_addr;
            length_d = length;
            state_d  = StAccept;
          end else begin
            state_d = StDone;
          end
        end
      end
      StAccept: begin
        in_ready = !abort;
        if (abort) begin
          state_d = StIdle;
        end else if (in_valid) begin
          mem_wdata_d = word;
          // Truncation to ADDR_W gives the required modulo wrap.
          mem_addr_d  = base_q + index_q[ADDR_W-1:0];
          state_d     = StWrite;
        end
      end
      StWrite: begin
        mem_we     = 1'b1;
        checksum_d = checksum_q ^ mem_wdata_q;
        index_d    = index_inc;
        if (abort) begin
          state_d = StIdle;
        end else if (index_inc == length_q) begin
          state_d = StDone;
        end else begin
          state_d = StAccept;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      length_q    <= '0;
      index_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      length_q    <= length_d;
      index_q     <= index_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      checksum_q  <= checksum_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed-vector bench for instruction_encoder with hand-computed expected words and addresses.
module tb_instruction_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  length;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic        fmt_imm;
  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [5:0]  immediate;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        done;
  logic [15:0] checksum;

  int n_checks = 0;
  int n_errors = 0;

  int         cyc = 0;
  int         wr_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] wr_addr[$];
  int         wr_cyc[$];

  instruction_encoder #(
    .ADDR_W (8),
    .LEN_W  (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt_imm   (fmt_imm),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .immediate (immediate),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr.push_back(mem_addr);
      wr_cyc.push_back(cyc);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input logic f, input logic [3:0] op, input logic [2:0] d,
                            input logic [2:0] s1, input logic [2:0] s2, input logic [5:0] imm);
    fmt_imm   = f;
    opcode    = op;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    immediate = imm;
  endtask

  task automatic start_burst(input logic [7:0] b, input logic [8:0] len);
    base_addr = b;
    length    = len;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  // Presents one field set for a single cycle once in_ready is seen; returns in the WRITE cycle.
  task automatic send_word(input logic f, input logic [3:0] op, input logic [2:0] d,
                           input logic [2:0] s1, input logic [2:0] s2, input logic [5:0] imm);
    int t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
    set_fields(f, op, d, s1, s2, imm);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_we"},    {31'd0, mem_we},    32'd0);
    check_eq({tag, "_done"},  {31'd0, done},      32'd0);
    check_eq({tag, "_ready"}, {31'd0, in_ready},  32'd0);
    check_eq({tag, "_addr"},  {24'd0, mem_addr},  32'd0);
    check_eq({tag, "_data"},  {16'd0, mem_wdata}, 32'd0);
    check_eq({tag, "_csum"},  {16'd0, checksum},  32'd0);
  endtask

  initial begin
    int w0;
    int t;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; length = '0;
    set_fields(1'b0, 4'h0, 3'd0, 3'd0, 3'd0, 6'd0);
    step();
    step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    step();

    // Register format, single word.
    start_burst(8'h10, 9'd1);
    check_eq("reg_ready", {31'd0, in_ready}, 32'd1);
    send_word(1'b0, 4'h1, 3'd6, 3'd0, 3'd2, 6'd0);
    check_eq("reg_we",    {31'd0, mem_we},    32'd1);
    check_eq("reg_addr",  {24'd0, mem_addr},  32'h10);
    check_eq("reg_data",  {16'd0, mem_wdata}, 32'h1C10);
    check_eq("reg_ready_in_write", {31'd0, in_ready}, 32'd0);
    step();
    check_eq("reg_done",  {31'd0, done},      32'd1);
    check_eq("reg_csum",  {16'd0, checksum},  32'h1C10);
    check_eq("reg_we_off", {31'd0, mem_we},   32'd0);
    step();
    check_eq("reg_done_pulse", {31'd0, done}, 32'd0);

    // Immediate format: rs2 must be ignored.
    start_burst(8'h20, 9'd1);
    send_word(1'b1, 4'h4, 3'd0, 3'd1, 3'd7, 6'b010000);
    check_eq("imm_addr", {24'd0, mem_addr},  32'h20);
    check_eq("imm_data", {16'd0, mem_wdata}, 32'h4050);
    step();
    check_eq("imm_done", {31'd0, done},     32'd1);
    check_eq("imm_csum", {16'd0, checksum}, 32'h4050);
    step();

    // Address wrap with in_valid held high.
    w0 = wr_cnt;
    set_fields(1'b0, 4'h3, 3'd1, 3'd2, 3'd3, 6'd0);
    in_valid = 1'b1;
    start_burst(8'hFE, 9'd3);
    t = 0;
    while (!done && t < 20) begin
      step();
      t++;
    end
    in_valid = 1'b0;
    check_eq("wrap_done",   {31'd0, done},     32'd1);
    check_eq("wrap_writes", wr_cnt - w0,       32'd3);
    check_eq("wrap_csum",   {16'd0, checksum}, 32'h3298);
    if (wr_addr.size() >= w0 + 3) begin
      check_eq("wrap_addr0", {24'd0, wr_addr[w0]},     32'hFE);
      check_eq("wrap_addr1", {24'd0, wr_addr[w0 + 1]}, 32'hFF);
      check_eq("wrap_addr2", {24'd0, wr_addr[w0 + 2]}, 32'h00);
      check_eq("wrap_gap1",  wr_cyc[w0 + 1] - wr_cyc[w0],     32'd2);
      check_eq("wrap_gap2",  wr_cyc[w0 + 2] - wr_cyc[w0 + 1], 32'd2);
    end else begin
      check_eq("wrap_queue", wr_addr.size(), w0 + 3);
    end
    step();

    // Zero-length burst.
    w0 = wr_cnt;
    start_burst(8'h33, 9'd0);
    check_eq("len0_done", {31'd0, done},     32'd1);
    check_eq("len0_we",   {31'd0, mem_we},   32'd0);
    check_eq("len0_csum", {16'd0, checksum}, 32'd0);
    step();
    check_eq("len0_done_pulse", {31'd0, done}, 32'd0);
    check_eq("len0_writes", wr_cnt - w0, 32'd0);

    // Abort in ACCEPT after two of four writes.
    w0 = done_cnt;
    t = wr_cnt;
    set_fields(1'b1, 4'h5, 3'd2, 3'd3, 3'd0, 6'h11);
    in_valid = 1'b1;
    start_burst(8'h40, 9'd4);
    while (!(wr_cnt - t == 2 && in_ready) && cyc < 2000) step();
    abort = 1'b1;
    #1;
    check_eq("abort_ready_low", {31'd0, in_ready}, 32'd0);
    step();
    abort = 1'b0;
    in_valid = 1'b0;
    repeat (5) step();
    check_eq("abort_writes", wr_cnt - t,    32'd2);
    check_eq("abort_no_done", done_cnt - w0, 32'd0);
    check_eq("abort_idle_ready", {31'd0, in_ready}, 32'd0);
    check_eq("abort_idle_we", {31'd0, mem_we}, 32'd0);

    // Reset asserted in WRITE, then a fresh burst started together with abort.
    w0 = done_cnt;
    start_burst(8'h80, 9'd4);
    send_word(1'b0, 4'h9, 3'd1, 3'd1, 3'd1, 6'd0);
    check_eq("rstw_we", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    t = wr_cnt;
    step();
    check_zero_outputs("rstw");
    rst_n = 1'b1;
    repeat (3) step();
    check_eq("rstw_no_write", wr_cnt - t - 1, 32'd0);
    check_eq("rstw_no_done",  done_cnt - w0,  32'd0);

    t = wr_cnt;
    abort = 1'b1;
    start_burst(8'h05, 9'd2);
    abort = 1'b0;
    send_word(1'b0, 4'hF, 3'd7, 3'd7, 3'd7, 6'd0);
    check_eq("post_addr0", {24'd0, mem_addr},  32'h05);
    check_eq("post_data0", {16'd0, mem_wdata}, 32'hFFF8);
    send_word(1'b1, 4'h2, 3'd1, 3'd3, 3'd5, 6'h2A);
    check_eq("post_addr1", {24'd0, mem_addr},  32'h06);
    check_eq("post_data1", {16'd0, mem_wdata}, 32'h22EA);
    step();
    check_eq("post_done", {31'd0, done},     32'd1);
    check_eq("post_csum", {16'd0, checksum}, 32'hDD12);
    step();
    check_eq("post_writes", wr_cnt - t, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
